// File: rtl/mux_arb_pkg.sv
// Shared types and sizing helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Beat counter must hold 0..MAX_BURST.
    function automatic int beat_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set req bit at or above start, modulo N,
// optionally skipping the current owner.
module rr_pick #(
    parameter int N = 8,
    parameter int M = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [M-1:0] start,
    input  logic         excl,
    input  logic [M-1:0] owner,
    output logic         found,
    output logic [M-1:0] win
);

    always_comb begin
        int j;
        logic [M-1:0] jm;
        found = 1'b0;
        win   = '0;
        j     = 0;
        jm    = '0;
        for (int i = 0; i < N; i++) begin
            // Explicit wrap so non-power-of-two N never indexes past N-1.
            j = int'(start) + i;
            if (j >= N) j = j - N;
            jm = M'(j);
            if (!found && req[jm] && !(excl && owner == jm)) begin
                found = 1'b1;
                win   = jm;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of an N-to-1 mux select; holds each grant for a burst of up to
// MAX_BURST accepted beats, or until the owner drops its request.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int M         = $clog2(N),
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic [N-1:0] grant,
    output logic [M-1:0] sel,
    output logic         out_valid,
    output logic         beat_accept,
    output logic         busy
);

    localparam int CW = beat_cnt_w(MAX_BURST);

    arb_state_e    state, state_n;
    logic [N-1:0]  grant_n;
    logic [M-1:0]  sel_n, ptr, ptr_n, sel_inc;
    logic [M-1:0]  pick_start, pick_win;
    logic          pick_excl, pick_found, take;
    logic [CW-1:0] cnt, cnt_n;
    logic          own_req, rel_a, rel_b, rel;

    assign own_req     = |(req & grant);
    assign out_valid   = own_req;
    assign beat_accept = out_valid & out_ready;
    assign busy        = (state == GRANT);
    assign sel_inc     = (sel == M'(N - 1)) ? '0 : sel + 1'b1;

    assign rel_a = busy & ~own_req;
    assign rel_b = beat_accept & (cnt == CW'(MAX_BURST - 1));
    assign rel   = rel_a | rel_b;

    // Searching from sel+1 leaves the outgoing owner as the last candidate.
    rr_pick #(.N(N), .M(M)) u_pick (
        .req   (req),
        .start (pick_start),
        .excl  (pick_excl),
        .owner (sel),
        .found (pick_found),
        .win   (pick_win)
    );

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        sel_n      = sel;
        ptr_n      = ptr;
        cnt_n      = cnt;
        pick_start = ptr;
        pick_excl  = 1'b0;
        take       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) take = 1'b1;
            end
            GRANT: begin
                pick_start = sel_inc;
                pick_excl  = rel_a;
                if (beat_accept) cnt_n = cnt + 1'b1;
                if (rel) begin
                    ptr_n = sel_inc;
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
        if (take) begin
            state_n = GRANT;
            sel_n   = pick_win;
            cnt_n   = '0;
            for (int i = 0; i < N; i++) grant_n[i] = (pick_win == M'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: N=8 and N=5 arbiters, expected owner per accepted beat queued up front.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       out_valid, beat_accept, busy;

    logic [4:0] req5;
    logic       ready5;
    logic [4:0] grant5;
    logic [2:0] sel5;
    logic       valid5, beat5, busy5;

    int tests = 0;
    int fails = 0;
    logic       mon_en  = 1'b0;
    logic       mon5_en = 1'b0;
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] ea, eb;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(8), .MAX_BURST(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .grant(grant), .sel(sel), .out_valid(out_valid),
        .beat_accept(beat_accept), .busy(busy)
    );

    mux_rr_arbiter #(.N(5), .MAX_BURST(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .out_ready(ready5),
        .grant(grant5), .sel(sel5), .out_valid(valid5),
        .beat_accept(beat5), .busy(busy5)
    );

    always @(negedge clk) begin
        if (mon_en && beat_accept) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL beat8: unexpected beat from sel=%0d, none expected", sel);
            end else begin
                ea = qa.pop_front();
                if (sel !== ea || grant !== (8'h01 << ea)) begin
                    fails++;
                    $display("FAIL beat8: sel=%0d grant=%h, expected sel=%0d", sel, grant, ea);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon5_en && beat5) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL beat5: unexpected beat from sel=%0d, none expected", sel5);
            end else begin
                eb = qb.pop_front();
                if (sel5 !== eb) begin
                    fails++;
                    $display("FAIL beat5: sel=%0d, expected sel=%0d", sel5, eb);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        mon_en = 1'b0; mon5_en = 1'b0;
        qa.delete(); qb.delete();
        rst_n = 1'b0; req = '0; out_ready = 1'b0; req5 = '0; ready5 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic push_a(input logic [2:0] o, input int n);
        for (int i = 0; i < n; i++) qa.push_back(o);
    endtask

    task automatic push_b(input logic [2:0] o, input int n);
        for (int i = 0; i < n; i++) qb.push_back(o);
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d/%0d expected beats never seen, required 0/0", name, qa.size(), qb.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
        #1;
        tests++;
        if (grant !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || beat_accept !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: grant=%h sel=%0d valid=%b accept=%b busy=%b, required all 0",
                     grant, sel, out_valid, beat_accept, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (grant !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant: grant=%h sel=%0d busy=%b, required 01/0/1", grant, sel, busy);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 8'hFF; out_ready = 1'b1; mon_en = 1'b1;
        for (int o = 0; o < 8; o++) push_a(3'(o), 4);
        push_a(3'd0, 4);
        @(posedge clk);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            tests++;
            if (beat_accept !== 1'b1) begin
                fails++;
                $display("FAIL rotation_gap: cycle %0d beat_accept=%b, required 1", i, beat_accept);
            end
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        check_drained("rotation_drain");
    endtask

    task automatic test_early_release();
        do_reset();
        req = 8'h28; out_ready = 1'b1; mon_en = 1'b1;
        push_a(3'd3, 2);
        @(posedge clk);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        req = 8'h24;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || beat_accept !== 1'b0) begin
            fails++;
            $display("FAIL early_drop: valid=%b accept=%b, required 0/0", out_valid, beat_accept);
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        tests++;
        if (grant !== 8'h20 || sel !== 3'd5) begin
            fails++;
            $display("FAIL early_handover: grant=%h sel=%0d, required 20/5", grant, sel);
        end
        check_drained("early_drain");
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h06; out_ready = 1'b0; mon_en = 1'b1;
        push_a(3'd1, 4);
        push_a(3'd2, 1);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (grant !== 8'h02 || beat_accept !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall: cycle %0d grant=%h accept=%b valid=%b, required 02/0/1",
                         i, grant, beat_accept, out_valid);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (beat_accept !== 1'b1) begin
                fails++;
                $display("FAIL bp_resume: beat %0d accept=%b, required 1", i, beat_accept);
            end
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        check_drained("bp_drain");
    endtask

    task automatic test_wrap5();
        do_reset();
        req5 = 5'b10001; ready5 = 1'b1; mon5_en = 1'b1;
        push_b(3'd0, 4); push_b(3'd4, 4); push_b(3'd0, 4); push_b(3'd4, 4);
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tests++;
            if (beat5 !== 1'b1 || sel5 > 3'd4) begin
                fails++;
                $display("FAIL wrap5: cycle %0d accept=%b sel=%0d, required 1 and sel<=4", i, beat5, sel5);
            end
        end
        @(posedge clk); #1;
        mon5_en = 1'b0;
        check_drained("wrap5_drain");
    endtask

    task automatic test_single5();
        do_reset();
        req5 = 5'b00100; ready5 = 1'b1; mon5_en = 1'b1;
        push_b(3'd2, 12);
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests++;
            if (beat5 !== 1'b1 || grant5 !== 5'b00100) begin
                fails++;
                $display("FAIL single5: cycle %0d accept=%b grant=%b, required 1/00100", i, beat5, grant5);
            end
        end
        @(posedge clk); #1;
        mon5_en = 1'b0;
        check_drained("single5_drain");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h48; out_ready = 1'b1; mon_en = 1'b1;
        push_a(3'd3, 4);
        push_a(3'd6, 1);
        @(posedge clk);
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (grant !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || beat_accept !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: grant=%h sel=%0d valid=%b accept=%b busy=%b, required all 0",
                     grant, sel, out_valid, beat_accept, busy);
        end
        check_drained("reset_mid_drain");
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (grant !== 8'h08 || sel !== 3'd3) begin
            fails++;
            $display("FAIL reset_mid_ptr: grant=%h sel=%0d, required 08/3", grant, sel);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0; req5 = '0; ready5 = 1'b0;
        test_reset();
        test_rotation();
        test_early_release();
        test_backpressure();
        test_wrap5();
        test_single5();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
